array_wr_ctrl: RTL and testbench

Write-path array controller, the counterpart of the read controller on the same frame interface. It accepts write frames from the MC FSM, each frame being {sof, eof, rw_flag, raddr, caddr, data}. It opens the addressed row (banksel_n), issues one CAS-write per beat with column address and data, and honours tRCD/tRAS/tWR/tRP. It then closes the row and pulses `write_finish`.

---
 rtl/array_mc_pkg.sv | 59 +++++
 rtl/array_mc_timer.sv | 33 +++
 rtl/array_wr_ctrl.sv | 232 +++++++++++++++++++++++
 tb/tb_array_wr_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/array_mc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : array_mc_pkg
//  Description : Definitions shared by the array read and write controllers:
//                FSM state encoding, frame field positions and the
//                cfg-to-counter-load helper.
//  Revision    : 1.0  initial release
// ============================================================================
package array_mc_pkg;

    // 3-bit encoded controller states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SRADDR = 3'd1,
        ST_RCD    = 3'd2,
        ST_WDATA  = 3'd3,
        ST_WLAST  = 3'd4,
        ST_WR     = 3'd5,
        ST_PRE    = 3'd6,
        ST_RP     = 3'd7
    } state_t;

    localparam int unsigned C_CNT_WIDTH = 8;

    // Frame layout, MSB to LSB: sof, eof, rw_flag, raddr, caddr, data
    function automatic int unsigned frame_caddr_lsb(input int unsigned dw);
        return dw;
    endfunction

    function automatic int unsigned frame_raddr_lsb(input int unsigned dw,
                                                    input int unsigned cw);
        return dw + cw;
    endfunction

    function automatic int unsigned frame_rw_pos(input int unsigned dw,
                                                 input int unsigned rw,
                                                 input int unsigned cw);
        return dw + cw + rw;
    endfunction

    function automatic int unsigned frame_eof_pos(input int unsigned dw,
                                                  input int unsigned rw,
                                                  input int unsigned cw);
        return dw + cw + rw + 1;
    endfunction

    function automatic int unsigned frame_sof_pos(input int unsigned dw,
                                                  input int unsigned rw,
                                                  input int unsigned cw);
        return dw + cw + rw + 2;
    endfunction

    // A timing value of 0 behaves like 1, so both load 0 into the counter
    function automatic logic [C_CNT_WIDTH-1:0] cfg_to_load(input logic [C_CNT_WIDTH-1:0] cfg);
        return (cfg == '0) ? '0 : cfg - 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/array_mc_timer.sv
`default_nettype none
// ============================================================================
//  Module      : array_mc_timer
//  Description : Loadable down-counter that saturates at zero and flags it.
//  Revision    : 1.0  initial release
// ============================================================================
module array_mc_timer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_cnt;

    // Load has priority; otherwise count down and hold at zero
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/array_wr_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : array_wr_ctrl
//  Description : Write-path array controller. Opens the addressed row, issues
//                one CAS-write per frame beat, honours tRCD/tRAS/tWR/tRP,
//                then precharges and pulses write_finish.
//  Revision    : 1.0  initial release
// ============================================================================
module array_wr_ctrl
    import array_mc_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 64,
    parameter int unsigned RADDR_WIDTH = 14,
    parameter int unsigned CADDR_WIDTH = 6,
    parameter int unsigned FRAME_WIDTH = DATA_WIDTH + RADDR_WIDTH + CADDR_WIDTH + 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             mc_tras_cfg,
    input  logic [7:0]             mc_trp_cfg,
    input  logic [7:0]             mc_trcd_cfg,
    input  logic [7:0]             mc_twr_cfg,
    input  logic [FRAME_WIDTH-1:0] axi_wframe_data,
    input  logic                   axi_wframe_valid,
    output logic                   axi_wframe_ready,
    output logic                   write_finish,
    output logic                   frame_err,
    output logic                   array_banksel_n,
    output logic [RADDR_WIDTH-1:0] array_raddr_wr,
    output logic                   array_cas_wr,
    output logic [CADDR_WIDTH-1:0] array_caddr_wr,
    output logic [DATA_WIDTH-1:0]  array_wdata
);

    localparam int unsigned C_CADDR_LSB = frame_caddr_lsb(DATA_WIDTH);
    localparam int unsigned C_RADDR_LSB = frame_raddr_lsb(DATA_WIDTH, CADDR_WIDTH);
    localparam int unsigned C_RW_POS    = frame_rw_pos(DATA_WIDTH, RADDR_WIDTH, CADDR_WIDTH);
    localparam int unsigned C_EOF_POS   = frame_eof_pos(DATA_WIDTH, RADDR_WIDTH, CADDR_WIDTH);
    localparam int unsigned C_SOF_POS   = frame_sof_pos(DATA_WIDTH, RADDR_WIDTH, CADDR_WIDTH);

    // Frame field decode
    logic                   w_f_sof;
    logic                   w_f_eof;
    logic                   w_f_rw;
    logic [RADDR_WIDTH-1:0] w_f_raddr;
    logic [CADDR_WIDTH-1:0] w_f_caddr;
    logic [DATA_WIDTH-1:0]  w_f_data;

    assign w_f_sof   = axi_wframe_data[C_SOF_POS];
    assign w_f_eof   = axi_wframe_data[C_EOF_POS];
    assign w_f_rw    = axi_wframe_data[C_RW_POS];
    assign w_f_raddr = axi_wframe_data[C_RADDR_LSB +: RADDR_WIDTH];
    assign w_f_caddr = axi_wframe_data[C_CADDR_LSB +: CADDR_WIDTH];
    assign w_f_data  = axi_wframe_data[DATA_WIDTH-1:0];

    state_t                 r_state;
    state_t                 w_state_nxt;

    logic                   r_eof_flag;
    logic [CADDR_WIDTH-1:0] r_caddr_lat;
    logic [DATA_WIDTH-1:0]  r_data_lat;
    logic                   r_banksel_n;
    logic [RADDR_WIDTH-1:0] r_raddr;
    logic                   r_cas;
    logic [CADDR_WIDTH-1:0] r_caddr;
    logic [DATA_WIDTH-1:0]  r_wdata;
    logic                   r_frame_err;

    logic                   w_ready;
    logic                   w_finish;
    logic                   w_latch;
    logic                   w_drop;
    logic                   w_cas_first;
    logic                   w_cas_beat;
    logic                   w_open;
    logic                   w_close;
    logic                   w_fsm_load;
    logic [7:0]             w_fsm_val;
    logic                   w_ras_load;
    logic                   w_fsm_zero;
    logic                   w_ras_zero;

    // Phase timer (tRCD / tWR / tRP) and row-active timer (tRAS)
    array_mc_timer #(.WIDTH(C_CNT_WIDTH)) u_fsm_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_fsm_load),
        .i_load_val (w_fsm_val),
        .o_zero     (w_fsm_zero)
    );

    array_mc_timer #(.WIDTH(C_CNT_WIDTH)) u_ras_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_ras_load),
        .i_load_val (cfg_to_load(mc_tras_cfg)),
        .o_zero     (w_ras_zero)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and per-state control strobes
    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        w_finish    = 1'b0;
        w_latch     = 1'b0;
        w_drop      = 1'b0;
        w_cas_first = 1'b0;
        w_cas_beat  = 1'b0;
        w_open      = 1'b0;
        w_close     = 1'b0;
        w_fsm_load  = 1'b0;
        w_fsm_val   = '0;
        w_ras_load  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_ready = 1'b1;
                if (axi_wframe_valid) begin
                    if (w_f_sof && w_f_rw) begin
                        w_latch     = 1'b1;
                        w_state_nxt = ST_SRADDR;
                    end else begin
                        w_drop = 1'b1;
                    end
                end
            end
            ST_SRADDR: begin
                w_open      = 1'b1;
                w_fsm_load  = 1'b1;
                w_fsm_val   = cfg_to_load(mc_trcd_cfg);
                w_ras_load  = 1'b1;
                w_state_nxt = ST_RCD;
            end
            ST_RCD: begin
                if (w_fsm_zero) begin
                    w_cas_first = 1'b1;
                    w_state_nxt = r_eof_flag ? ST_WLAST : ST_WDATA;
                end
            end
            ST_WDATA: begin
                // Blocking the beat during the strobe cycle spaces CASes by 2
                w_ready = ~r_cas;
                if (axi_wframe_valid && !r_cas) begin
                    w_cas_beat = 1'b1;
                    if (w_f_eof) begin
                        w_state_nxt = ST_WLAST;
                    end
                end
            end
            ST_WLAST: begin
                w_fsm_load  = 1'b1;
                w_fsm_val   = cfg_to_load(mc_twr_cfg);
                w_state_nxt = ST_WR;
            end
            ST_WR: begin
                if (w_fsm_zero && w_ras_zero) begin
                    w_state_nxt = ST_PRE;
                end
            end
            ST_PRE: begin
                w_close     = 1'b1;
                w_fsm_load  = 1'b1;
                w_fsm_val   = cfg_to_load(mc_trp_cfg);
                w_state_nxt = ST_RP;
            end
            ST_RP: begin
                if (w_fsm_zero) begin
                    w_finish    = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Registered array-side outputs and the latched first beat
    always_ff @(posedge clk) begin
        if (rst) begin
            r_eof_flag  <= 1'b0;
            r_caddr_lat <= '0;
            r_data_lat  <= '0;
            r_banksel_n <= 1'b1;
            r_raddr     <= '0;
            r_cas       <= 1'b0;
            r_caddr     <= '0;
            r_wdata     <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_cas       <= w_cas_first | w_cas_beat;
            r_frame_err <= w_drop;
            if (w_latch) begin
                r_raddr     <= w_f_raddr;
                r_caddr_lat <= w_f_caddr;
                r_data_lat  <= w_f_data;
                r_eof_flag  <= w_f_eof;
            end
            if (w_cas_first) begin
                r_caddr <= r_caddr_lat;
                r_wdata <= r_data_lat;
            end else if (w_cas_beat) begin
                r_caddr <= w_f_caddr;
                r_wdata <= w_f_data;
            end
            if (w_open) begin
                r_banksel_n <= 1'b0;
            end else if (w_close) begin
                r_banksel_n <= 1'b1;
            end
        end
    end

    assign axi_wframe_ready = w_ready;
    assign write_finish     = w_finish;
    assign frame_err        = r_frame_err;
    assign array_banksel_n  = r_banksel_n;
    assign array_raddr_wr   = r_raddr;
    assign array_cas_wr     = r_cas;
    assign array_caddr_wr   = r_caddr;
    assign array_wdata      = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_array_wr_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_array_wr_ctrl
//  Description : Directed self-checking bench for array_wr_ctrl.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_array_wr_ctrl;

    localparam int unsigned DW = 64;
    localparam int unsigned RW = 14;
    localparam int unsigned CW = 6;
    localparam int unsigned FW = DW + RW + CW + 3;

    logic          clk;
    logic          rst;
    logic [7:0]    tras;
    logic [7:0]    trp;
    logic [7:0]    trcd;
    logic [7:0]    twr;
    logic [FW-1:0] fdata;
    logic          fvalid;
    logic          fready;
    logic          wfin;
    logic          ferr;
    logic          bsel_n;
    logic [RW-1:0] raddr;
    logic          cas;
    logic [CW-1:0] caddr;
    logic [DW-1:0] wdata;

    int checks   = 0;
    int failures = 0;

    array_wr_ctrl #(
        .DATA_WIDTH  (DW),
        .RADDR_WIDTH (RW),
        .CADDR_WIDTH (CW)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .mc_tras_cfg      (tras),
        .mc_trp_cfg       (trp),
        .mc_trcd_cfg      (trcd),
        .mc_twr_cfg       (twr),
        .axi_wframe_data  (fdata),
        .axi_wframe_valid (fvalid),
        .axi_wframe_ready (fready),
        .write_finish     (wfin),
        .frame_err        (ferr),
        .array_banksel_n  (bsel_n),
        .array_raddr_wr   (raddr),
        .array_cas_wr     (cas),
        .array_caddr_wr   (caddr),
        .array_wdata      (wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // Per-cycle capture: bit c holds the value seen in cycle c after start
    logic [FW-1:0] frames [0:7];
    int            nframes;
    logic [31:0]   bs_v, cas_v, fin_v, rdy_v, err_v;
    logic [CW-1:0] cad [0:31];
    logic [DW-1:0] wd  [0:31];

    function automatic logic [FW-1:0] mk(input logic sof, input logic eof, input logic rw,
                                         input logic [RW-1:0] ra, input logic [CW-1:0] ca,
                                         input logic [DW-1:0] d);
        return {sof, eof, rw, ra, ca, d};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Presents frames[0..nframes-1] under valid/ready and records n cycles
    task automatic capture(input int n);
        int  idx;
        logic acc;
        idx   = 0;
        bs_v  = '0;
        cas_v = '0;
        fin_v = '0;
        rdy_v = '0;
        err_v = '0;
        for (int c = 0; c < n; c++) begin
            fvalid = (idx < nframes);
            fdata  = (idx < nframes) ? frames[idx] : '0;
            #1;
            bs_v[c]  = bsel_n;
            cas_v[c] = cas;
            fin_v[c] = wfin;
            rdy_v[c] = fready;
            err_v[c] = ferr;
            cad[c]   = caddr;
            wd[c]    = wdata;
            acc      = fvalid && fready;
            @(posedge clk);
            #2;
            if (acc) idx++;
        end
        fvalid = 1'b0;
        fdata  = '0;
    endtask

    initial begin
        rst    = 1'b1;
        fvalid = 1'b0;
        fdata  = '0;
        tras   = 8'd4;
        trp    = 8'd2;
        trcd   = 8'd3;
        twr    = 8'd2;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;

        // Reset state
        check("rst_banksel", bsel_n, 1);
        check("rst_cas",     cas,    0);
        check("rst_finish",  wfin,   0);
        check("rst_err",     ferr,   0);
        check("rst_caddr",   caddr,  0);
        check("rst_wdata",   wdata,  0);
        check("rst_raddr",   raddr,  0);
        check("rst_ready",   fready, 1);

        // Single beat, trcd=3 tras=4 twr=2 trp=2
        frames[0] = mk(1, 1, 1, 14'h1234, 6'd5, 64'hA5A5_A5A5_A5A5_A5A5);
        nframes   = 1;
        capture(32);
        check("s1_banksel", bs_v,  32'hFFFF_FE03);
        check("s1_cas",     cas_v, 32'h0000_0020);
        check("s1_finish",  fin_v, 32'h0000_0400);
        check("s1_ready",   rdy_v, 32'hFFFF_F801);
        check("s1_err",     err_v, 32'h0);
        check("s1_caddr",   cad[5], 6'd5);
        check("s1_wdata",   wd[5],  64'hA5A5_A5A5_A5A5_A5A5);
        check("s1_raddr",   raddr,  14'h1234);

        // 4-beat burst with valid held high; sof/rw_flag vary on later beats
        trcd = 8'd2; tras = 8'd2; twr = 8'd1; trp = 8'd1;
        frames[0] = mk(1, 0, 1, 14'h0ABC, 6'd0, 64'h0000_0000_0000_00D0);
        frames[1] = mk(0, 0, 0, 14'h0000, 6'd1, 64'h0000_0000_0000_00D1);
        frames[2] = mk(0, 0, 1, 14'h0000, 6'd2, 64'h0000_0000_0000_00D2);
        frames[3] = mk(0, 1, 0, 14'h0000, 6'd3, 64'h0000_0000_0000_00D3);
        nframes   = 4;
        capture(32);
        check("b_cas",       cas_v, 32'h0000_0550);
        check("b_ready_cas", rdy_v & cas_v, 32'h0);
        check("b_ready",     rdy_v, 32'hFFFF_C2A1);
        check("b_banksel",   bs_v,  32'hFFFF_E003);
        check("b_finish",    fin_v, 32'h0000_2000);
        check("b_caddr0",    cad[4],  6'd0);
        check("b_caddr1",    cad[6],  6'd1);
        check("b_caddr2",    cad[8],  6'd2);
        check("b_caddr3",    cad[10], 6'd3);
        check("b_wdata3",    wd[10],  64'hD3);
        check("b_raddr",     raddr,   14'h0ABC);

        // tRAS dominant: precharge waits for ras_cnt
        trcd = 8'd1; tras = 8'd20; twr = 8'd1; trp = 8'd1;
        frames[0] = mk(1, 1, 1, 14'h0001, 6'd7, 64'h77);
        nframes   = 1;
        capture(32);
        check("ras_banksel", bs_v,  32'hFF80_0003);
        check("ras_cas",     cas_v, 32'h0000_0008);
        check("ras_finish",  fin_v, 32'h0080_0000);

        // All timing cfg zero behaves as one
        trcd = 8'd0; tras = 8'd0; twr = 8'd0; trp = 8'd0;
        frames[0] = mk(1, 1, 1, 14'h0002, 6'd8, 64'h88);
        nframes   = 1;
        capture(32);
        check("z_banksel", bs_v,  32'hFFFF_FFC3);
        check("z_cas",     cas_v, 32'h0000_0008);
        check("z_finish",  fin_v, 32'h0000_0040);
        check("z_caddr",   cad[3], 6'd8);

        // Dropped frames: sof=0, then rw_flag=0
        frames[0] = mk(0, 1, 1, 14'h0003, 6'd1, 64'h1);
        frames[1] = mk(1, 1, 0, 14'h0004, 6'd2, 64'h2);
        nframes   = 2;
        capture(8);
        check("d_err",     err_v, 32'h0000_0006);
        check("d_ready",   rdy_v, 32'h0000_00FF);
        check("d_banksel", bs_v,  32'h0000_00FF);
        check("d_cas",     cas_v, 32'h0);
        check("d_finish",  fin_v, 32'h0);

        // Reset in the middle of a burst
        trcd = 8'd2; tras = 8'd2; twr = 8'd1; trp = 8'd1;
        frames[0] = mk(1, 0, 1, 14'h0100, 6'd0, 64'hE0);
        frames[1] = mk(0, 0, 1, 14'h0000, 6'd1, 64'hE1);
        frames[2] = mk(0, 0, 1, 14'h0000, 6'd2, 64'hE2);
        frames[3] = mk(0, 1, 1, 14'h0000, 6'd3, 64'hE3);
        nframes   = 4;
        capture(7);
        check("m_cas_pre", cas_v, 32'h0000_0050);
        #1;
        check("m_banksel_pre", bsel_n, 0);
        rst = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("m_banksel", bsel_n, 1);
        check("m_cas",     cas,    0);
        check("m_ready",   fready, 1);
        check("m_finish",  wfin,   0);
        @(posedge clk);
        #2;

        // A fresh frame after the reset completes normally
        frames[0] = mk(1, 1, 1, 14'h0200, 6'd9, 64'h1122_3344_5566_7788);
        nframes   = 1;
        capture(32);
        check("n_cas",     cas_v, 32'h0000_0010);
        check("n_banksel", bs_v,  32'hFFFF_FF83);
        check("n_finish",  fin_v, 32'h0000_0080);
        check("n_caddr",   cad[4], 6'd9);
        check("n_wdata",   wd[4],  64'h1122_3344_5566_7788);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
